// File: rtl/imem_loader_if.sv
// imem_loader_if: byte-stream valid/ready channel into the instruction memory loader.
// master = host byte source (drives in_valid/in_data), slave = loader (drives in_ready).
interface imem_loader_if;
   logic       in_valid;
   logic [7:0] in_data;
   logic       in_ready;

   modport master (
      output in_valid,
      output in_data,
      input  in_ready
   );

   modport slave (
      input  in_valid,
      input  in_data,
      output in_ready
   );
endinterface

// File: rtl/imem_loader.sv
// imem_loader: assembles a big-endian byte stream into instruction words and writes them
// to consecutive instruction memory addresses, then checks a trailing XOR checksum.
// Ports: clk, reset_n (async, active-low); start/start_addr/word_count load request;
// bus (slave) byte stream; mem_we/mem_addr/mem_wdata write port; busy, done, err status.
module imem_loader #(
   parameter int ADDR_BIT_WIDTH = 11,
   parameter int DATA_BIT_WIDTH = 32
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      start,
   input  logic [ADDR_BIT_WIDTH-1:0] start_addr,
   input  logic [ADDR_BIT_WIDTH:0]   word_count,
   imem_loader_if.slave              bus,
   output logic                      mem_we,
   output logic [ADDR_BIT_WIDTH-1:0] mem_addr,
   output logic [DATA_BIT_WIDTH-1:0] mem_wdata,
   output logic                      busy,
   output logic                      done,
   output logic                      err
);
   localparam int AW    = ADDR_BIT_WIDTH;
   localparam int DW    = DATA_BIT_WIDTH;
   localparam int BYTES = DW / 8;
   localparam int BW    = (BYTES > 1) ? $clog2(BYTES) : 1;
   localparam logic [BW-1:0] LAST = BW'(BYTES - 1);
   localparam logic [AW:0]   ONE  = (AW+1)'(1);

   typedef enum logic [2:0] {
      IDLE, DATA, WRITE, CSUM, DONE
   } state_t;

   state_t          state;
   state_t          state_nx;
   logic [AW-1:0]   addr_q;
   logic [AW:0]     rem_q;
   logic [DW-1:0]   word_q;
   logic [DW-1:0]   csum_q;
   logic [BW-1:0]   bcnt_q;
   logic            err_q;
   logic [DW-1:0]   word_sh;
   logic            rx;
   logic            take;
   logic            last;

   // in_ready comes from state alone, so take never loops back through in_ready
   assign rx      = (state == DATA) || (state == CSUM);
   assign take    = bus.in_valid & rx;
   assign last    = take & (bcnt_q == LAST);
   assign word_sh = (word_q << 8) | DW'(bus.in_data);

   assign bus.in_ready = rx;
   assign busy         = (state != IDLE);
   assign done         = (state == DONE);
   assign err          = err_q;
   assign mem_addr     = addr_q;
   assign mem_wdata    = word_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      mem_we   = 1'b0;
      unique case (state)
         IDLE: begin
            if (start)
               state_nx = (word_count != '0) ? DATA : CSUM;
         end
         DATA: begin
            if (last) state_nx = WRITE;
         end
         WRITE: begin
            mem_we   = 1'b1;
            state_nx = (rem_q == ONE) ? CSUM : DATA;
         end
         CSUM: begin
            if (last) state_nx = DONE;
         end
         DONE: begin
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         addr_q <= '0;
         rem_q  <= '0;
         word_q <= '0;
         csum_q <= '0;
         bcnt_q <= '0;
         err_q  <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (start) begin
                  addr_q <= start_addr;
                  rem_q  <= word_count;
                  csum_q <= '0;
                  bcnt_q <= '0;
                  err_q  <= 1'b0;
               end
            end
            DATA: begin
               if (take) begin
                  word_q <= word_sh;
                  bcnt_q <= last ? '0 : bcnt_q + 1'b1;
               end
            end
            WRITE: begin
               csum_q <= csum_q ^ word_q;
               addr_q <= addr_q + 1'b1;
               rem_q  <= rem_q - ONE;
            end
            CSUM: begin
               if (take) begin
                  word_q <= word_sh;
                  bcnt_q <= last ? '0 : bcnt_q + 1'b1;
                  if (last) err_q <= (word_sh != csum_q);
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: table-driven and randomized loads against a queue-based reference model.
// Covers checksum ok/bad, address wrap, zero-length load, stalls, ignored restart, mid-load reset.
module tb_imem_loader;
   localparam int AW = 11;
   localparam int DW = 32;
   localparam int NB = DW / 8;
   localparam int BUDGET = 2000;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          start = 1'b0;
   logic [AW-1:0] start_addr = '0;
   logic [AW:0]   word_count = '0;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic          busy;
   logic          done;
   logic          err;

   int n_chk = 0;
   int n_fail = 0;

   imem_loader_if bus ();

   imem_loader #(
      .ADDR_BIT_WIDTH (AW),
      .DATA_BIT_WIDTH (DW)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .start      (start),
      .start_addr (start_addr),
      .word_count (word_count),
      .bus        (bus),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .busy       (busy),
      .done       (done),
      .err        (err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [AW-1:0] saddr;
      int            wcnt;
      logic [DW-1:0] w0;
      logic [DW-1:0] w1;
      bit            bad;
      bit            gaps;
      bit            restart;
      bit            exp_err;
   } vec_t;

   task automatic check(input string name, input logic [63:0] act,
                        input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, " in_ready"}, 64'(bus.in_ready), 64'd0);
      check({tag, " mem_we"}, 64'(mem_we), 64'd0);
      check({tag, " busy"}, 64'(busy), 64'd0);
      check({tag, " done"}, 64'(done), 64'd0);
      check({tag, " err"}, 64'(err), 64'd0);
      check({tag, " mem_addr"}, 64'(mem_addr), 64'd0);
      check({tag, " mem_wdata"}, 64'(mem_wdata), 64'd0);
   endtask

   function automatic vec_t mk(input logic [AW-1:0] sa, input int wc,
                               input logic [DW-1:0] a, input logic [DW-1:0] b,
                               input bit bad, input bit gaps, input bit rs,
                               input bit ee);
      vec_t v;
      v.saddr = sa; v.wcnt = wc; v.w0 = a; v.w1 = b;
      v.bad = bad; v.gaps = gaps; v.restart = rs; v.exp_err = ee;
      return v;
   endfunction

   task automatic run_load(input vec_t v);
      logic [7:0]    bytes[$];
      logic [AW-1:0] ea[$];
      logic [DW-1:0] ed[$];
      logic [DW-1:0] x;
      logic [DW-1:0] w;
      int            got;
      int            idx;
      int            k;
      int            ndone;
      int            done_k;
      bit            stable;
      bit            vld;
      logic          r0;
      x = '0;
      for (int i = 0; i < v.wcnt; i++) begin
         w = (i == 0) ? v.w0 : (i == 1) ? v.w1 : DW'($urandom);
         x ^= w;
         ea.push_back(AW'(int'(v.saddr) + i));
         ed.push_back(w);
         for (int b = NB - 1; b >= 0; b--) bytes.push_back(w[8*b +: 8]);
      end
      w = v.bad ? ((x != '0) ? '0 : DW'(1)) : x;
      for (int b = NB - 1; b >= 0; b--) bytes.push_back(w[8*b +: 8]);

      @(negedge clk);
      start = 1'b1;
      start_addr = v.saddr;
      word_count = (AW+1)'(v.wcnt);
      bus.in_valid = 1'b0;
      @(negedge clk);
      start = 1'b0;
      start_addr = AW'($urandom);
      word_count = (AW+1)'($urandom);
      check("busy after start", 64'(busy), 64'd1);
      check("in_ready after start", 64'(bus.in_ready), 64'd1);
      check("err cleared by start", 64'(err), 64'd0);

      got = 0; idx = 0; k = 1; ndone = 0; done_k = 0; stable = 1'b1;
      while (ndone == 0 && k <= BUDGET) begin
         if (mem_we) begin
            if (got < ea.size()) begin
               check($sformatf("write%0d addr", got), 64'(mem_addr), 64'(ea[got]));
               check($sformatf("write%0d data", got), 64'(mem_wdata), 64'(ed[got]));
            end else begin
               check("extra write", 64'(got), 64'(ea.size() - 1));
            end
            got++;
         end
         if (done) begin
            ndone++;
            done_k = k;
            check("err at done", 64'(err), 64'(v.exp_err));
         end
         vld = (idx < bytes.size()) && (!v.gaps || $urandom_range(0, 2) != 0);
         r0 = bus.in_ready;
         bus.in_valid = ~vld;
         #1;
         if (bus.in_ready !== r0) stable = 1'b0;
         bus.in_valid = vld;
         bus.in_data = vld ? bytes[idx] : 8'($urandom);
         #1;
         if (bus.in_ready !== r0) stable = 1'b0;
         if (vld && r0) idx++;
         if (v.restart && k == 7) begin
            start = 1'b1;
            start_addr = AW'($urandom);
            word_count = (AW+1)'($urandom_range(1, 9));
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
         k++;
      end
      start = 1'b0;
      bus.in_valid = 1'b0;
      check("done seen", 64'(ndone), 64'd1);
      check("write count", 64'(got), 64'(ea.size()));
      check("bytes consumed", 64'(idx), 64'(bytes.size()));
      check("in_ready independent of in_valid", 64'(stable), 64'd1);
      if (!v.gaps && ndone == 1)
         check("load latency", 64'(done_k), 64'(5 * v.wcnt + 5));
      for (int c = 0; c < 3; c++) begin
         if (done || busy || mem_we || (err !== v.exp_err))
            check("idle after done", {60'd0, done, busy, mem_we, err},
                  {63'd0, v.exp_err});
         @(negedge clk);
      end
      check("err holds", 64'(err), 64'(v.exp_err));
   endtask

   vec_t tbl[7];

   initial begin
      vec_t rv;
      int   nacc;
      int   nwr;
      int   guard;
      logic [7:0] rb[8];

      tbl[0] = mk(11'h010, 2, 32'h12345678, 32'hCAFEBABE, 0, 0, 0, 0);
      tbl[1] = mk(11'h010, 2, 32'h12345678, 32'hCAFEBABE, 1, 0, 0, 1);
      tbl[2] = mk(11'h010, 2, 32'h12345678, 32'hCAFEBABE, 0, 0, 0, 0);
      tbl[3] = mk(11'h7FF, 2, 32'h11111111, 32'h22222222, 0, 0, 0, 0);
      tbl[4] = mk(11'h123, 0, 32'h0, 32'h0, 0, 0, 0, 0);
      tbl[5] = mk(11'h010, 2, 32'h12345678, 32'hCAFEBABE, 0, 1, 1, 0);
      tbl[6] = mk(11'h3FE, 3, 32'hAABBCCDD, 32'h01020304, 1, 1, 0, 1);

      bus.in_valid = 1'b0;
      bus.in_data = 8'h00;
      repeat (2) @(negedge clk);
      check_reset_vals("reset");
      reset_n = 1'b1;
      @(negedge clk);
      check_reset_vals("idle");

      for (int i = 0; i < 7; i++) run_load(tbl[i]);

      for (int i = 0; i < 8; i++) begin
         rv = mk(AW'($urandom), $urandom_range(0, 5), DW'($urandom),
                 DW'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 0);
         rv.exp_err = rv.bad;
         run_load(rv);
      end

      rb = '{8'h12, 8'h34, 8'h56, 8'h78, 8'hCA, 8'hFE, 8'hBA, 8'hBE};
      @(negedge clk);
      start = 1'b1;
      start_addr = 11'h040;
      word_count = 12'd2;
      @(negedge clk);
      start = 1'b0;
      nacc = 0; nwr = 0; guard = 0;
      while (nacc < 6 && guard < 100) begin
         if (mem_we) begin
            nwr++;
            check("reset test write addr", 64'(mem_addr), 64'h040);
            check("reset test write data", 64'(mem_wdata), 64'h12345678);
         end
         if (done) check("reset test no done", 64'(done), 64'd0);
         bus.in_valid = 1'b1;
         bus.in_data = rb[nacc];
         if (bus.in_ready) nacc++;
         @(negedge clk);
         guard++;
      end
      bus.in_valid = 1'b0;
      check("reset test bytes", 64'(nacc), 64'd6);
      check("reset test busy mid-load", 64'(busy), 64'd1);
      reset_n = 1'b0;
      #1;
      check("reset test write count", 64'(nwr), 64'd1);
      check_reset_vals("async reset");
      @(negedge clk);
      check_reset_vals("held reset");
      reset_n = 1'b1;
      @(negedge clk);
      run_load(tbl[0]);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end
endmodule
